// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
//   Definitions shared by the decoder, ALU, LSU and the per-thread register
//   file:
//     - core FSM state encodings (3 bits)
//     - writeback source select codes (reg_input_mux, 2 bits)
//     - indices of the read-only special registers R13..R15
//   No ports; imported with "import gpu_pkg::*;".
// ---------------------------------------------------------------------------
package gpu_pkg;

    // Core FSM state encodings.
    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;

    // Writeback source select. Code 2'b11 is reserved and performs no write.
    localparam logic [1:0] MUX_ALU      = 2'b00;
    localparam logic [1:0] MUX_MEMORY   = 2'b01;
    localparam logic [1:0] MUX_CONSTANT = 2'b10;
    localparam logic [1:0] MUX_RESERVED = 2'b11;

    // Register file geometry and special-register indices.
    localparam int         NUM_REGS       = 16;
    localparam logic [3:0] BLOCK_IDX_REG  = 4'd13;
    localparam logic [3:0] BLOCK_DIM_REG  = 4'd14;
    localparam logic [3:0] THREAD_IDX_REG = 4'd15;

    // General-purpose registers are everything below the special block.
    function automatic logic is_gp_reg(input logic [3:0] addr);
        return addr < BLOCK_IDX_REG;
    endfunction

endpackage : gpu_pkg

// File: rtl/thread_regfile.sv
// ---------------------------------------------------------------------------
// thread_regfile
//   Per-thread register file: 16 x DATA_BITS. It supplies the registered
//   rs/rt operands to the per-thread ALU/LSU and captures writeback from the
//   ALU, the LSU or a decoded immediate.
//   R13 = block index (refreshed from block_id on every enabled cycle),
//   R14 = block dimension, R15 = thread index. All three are read-only.
//
// Ports
//   clk                       system clock
//   reset                     synchronous, active-high; highest priority
//   enable                    thread active; 0 freezes all state
//   block_id                  block index currently dispatched to the core
//   core_state                core FSM state (gpu_pkg CORE_* encodings)
//   decoded_rd_address        destination register
//   decoded_rs_address        source register 1
//   decoded_rt_address        source register 2
//   decoded_reg_write_enable  instruction writes rd
//   decoded_reg_input_mux     writeback source select
//   decoded_immediate         constant for CONSTANT writeback
//   alu_out                   ALU result (valid in UPDATE)
//   lsu_out                   load data (valid in UPDATE)
//   rs, rt                    registered operands, loaded in REQUEST
// ---------------------------------------------------------------------------
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX_VAL = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] regs_q [NUM_REGS];
    logic [DATA_BITS-1:0] regs_d [NUM_REGS];
    logic [DATA_BITS-1:0] rs_q, rs_d;
    logic [DATA_BITS-1:0] rt_q, rt_d;

    logic                 wb_valid;
    logic [DATA_BITS-1:0] wb_data;

    // Writeback source select. The reserved code yields no write at all.
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        if (enable && core_state == CORE_UPDATE && decoded_reg_write_enable
            && is_gp_reg(decoded_rd_address)) begin
            case (decoded_reg_input_mux)
                MUX_ALU: begin
                    wb_valid = 1'b1;
                    wb_data  = alu_out;
                end
                MUX_MEMORY: begin
                    wb_valid = 1'b1;
                    wb_data  = lsu_out;
                end
                MUX_CONSTANT: begin
                    wb_valid = 1'b1;
                    wb_data  = decoded_immediate;
                end
                default: begin
                    wb_valid = 1'b0;
                    wb_data  = '0;
                end
            endcase
        end
    end

    // Next-state for storage and operand latches.
    always_comb begin
        regs_d = regs_q;
        rs_d   = rs_q;
        rt_d   = rt_q;

        if (enable) begin
            // Operands come from the current (pre-edge) contents, so a read of
            // R13 returns the block_id captured on the previous edge.
            if (core_state == CORE_REQUEST) begin
                rs_d = regs_q[decoded_rs_address];
                rt_d = regs_q[decoded_rt_address];
            end

            if (wb_valid) begin
                regs_d[decoded_rd_address] = wb_data;
            end

            regs_d[BLOCK_IDX_REG] = block_id;
        end

        // Special registers beyond R13 never change after reset.
        regs_d[BLOCK_DIM_REG]  = BLOCK_DIM_VAL;
        regs_d[THREAD_IDX_REG] = THREAD_IDX_VAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[BLOCK_DIM_REG]  <= BLOCK_DIM_VAL;
            regs_q[THREAD_IDX_REG] <= THREAD_IDX_VAL;
            rs_q <= '0;
            rt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rs_q <= rs_d;
            rt_q <= rt_d;
        end
    end

    assign rs = rs_q;
    assign rt = rt_q;

endmodule : thread_regfile

// File: tb/tb_thread_regfile.sv
// ---------------------------------------------------------------------------
// tb_thread_regfile
//   Self-checking bench for thread_regfile (THREAD_ID=2, THREADS_PER_BLOCK=4,
//   DATA_BITS=8). A reference model of the 16 registers and the two operand
//   outputs is advanced on every clock edge from the behavioural rules; rs/rt
//   are compared against it after every edge, with extra constant checks on
//   the directed scenarios, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_thread_regfile;

    localparam int TPB = 4;
    localparam int TID = 2;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DB-1:0] block_id;
    logic [2:0]    core_state;
    logic [3:0]    decoded_rd_address;
    logic [3:0]    decoded_rs_address;
    logic [3:0]    decoded_rt_address;
    logic          decoded_reg_write_enable;
    logic [1:0]    decoded_reg_input_mux;
    logic [DB-1:0] decoded_immediate;
    logic [DB-1:0] alu_out;
    logic [DB-1:0] lsu_out;
    logic [DB-1:0] rs;
    logic [DB-1:0] rt;

    thread_regfile #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID        (TID),
        .DATA_BITS        (DB)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .block_id                (block_id),
        .core_state              (core_state),
        .decoded_rd_address      (decoded_rd_address),
        .decoded_rs_address      (decoded_rs_address),
        .decoded_rt_address      (decoded_rt_address),
        .decoded_reg_write_enable(decoded_reg_write_enable),
        .decoded_reg_input_mux   (decoded_reg_input_mux),
        .decoded_immediate       (decoded_immediate),
        .alu_out                 (alu_out),
        .lsu_out                 (lsu_out),
        .rs                      (rs),
        .rt                      (rt)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_errors  = 0;

    // Reference model state.
    logic [DB-1:0] m_reg [16];
    logic [DB-1:0] m_rs;
    logic [DB-1:0] m_rt;

    task automatic check_eq(input string tag, input logic [DB-1:0] obs,
                            input logic [DB-1:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the register-file rules to the model using the inputs present at
    // the clock edge.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 16; i++) m_reg[i] = '0;
            m_reg[14] = DB'(TPB);
            m_reg[15] = DB'(TID);
            m_rs = '0;
            m_rt = '0;
        end else if (enable) begin
            if (core_state == 3'd3) begin
                m_rs = m_reg[decoded_rs_address];
                m_rt = m_reg[decoded_rt_address];
            end
            if (core_state == 3'd6 && decoded_reg_write_enable
                && decoded_rd_address <= 4'd12) begin
                if (decoded_reg_input_mux == 2'd0) m_reg[decoded_rd_address] = alu_out;
                if (decoded_reg_input_mux == 2'd1) m_reg[decoded_rd_address] = lsu_out;
                if (decoded_reg_input_mux == 2'd2) m_reg[decoded_rd_address] = decoded_immediate;
            end
            m_reg[13] = block_id;
        end
    endtask

    // One clock: model advances on the edge, outputs are checked 1 time unit
    // later, and stimulus may then change.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("rs_model", rs, m_rs);
        check_eq("rt_model", rt, m_rt);
    endtask

    task automatic request(input logic [3:0] a, input logic [3:0] b);
        core_state         = 3'd3;
        decoded_rs_address = a;
        decoded_rt_address = b;
        cycle();
        core_state = 3'd4;
    endtask

    task automatic update(input logic [3:0] rd, input logic [1:0] mux,
                          input logic [DB-1:0] imm, input logic [DB-1:0] alu,
                          input logic [DB-1:0] lsu);
        core_state               = 3'd6;
        decoded_rd_address       = rd;
        decoded_reg_input_mux    = mux;
        decoded_immediate        = imm;
        alu_out                  = alu;
        lsu_out                  = lsu;
        decoded_reg_write_enable = 1'b1;
        cycle();
        decoded_reg_write_enable = 1'b0;
        core_state               = 3'd7;
    endtask

    initial begin
        reset                    = 1'b1;
        enable                   = 1'b1;
        block_id                 = 8'd7;
        core_state               = 3'd0;
        decoded_rd_address       = '0;
        decoded_rs_address       = '0;
        decoded_rt_address       = '0;
        decoded_reg_write_enable = 1'b0;
        decoded_reg_input_mux    = '0;
        decoded_immediate        = '0;
        alu_out                  = '0;
        lsu_out                  = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_rs = '0;
        m_rt = '0;

        // Reset and special registers.
        cycle();
        check_eq("reset_rs", rs, 8'h00);
        check_eq("reset_rt", rt, 8'h00);
        reset = 1'b0;
        cycle();
        request(4'd13, 4'd15);
        check_eq("r13_blkid", rs, 8'h07);
        check_eq("r15_tid", rt, 8'h02);
        request(4'd14, 4'd0);
        check_eq("r14_dim", rs, 8'h04);
        check_eq("r0_reset", rt, 8'h00);

        // Writeback sources.
        update(4'd3, 2'd2, 8'h5A, 8'h00, 8'h00);
        request(4'd3, 4'd3);
        check_eq("imm_rs", rs, 8'h5A);
        check_eq("imm_rt", rt, 8'h5A);
        update(4'd3, 2'd0, 8'h00, 8'h11, 8'h00);
        request(4'd3, 4'd3);
        check_eq("alu_wb", rs, 8'h11);
        update(4'd3, 2'd1, 8'h00, 8'h00, 8'hC3);
        request(4'd3, 4'd3);
        check_eq("lsu_wb", rt, 8'hC3);

        // Writes to special registers are dropped; R13 keeps tracking.
        update(4'd14, 2'd2, 8'hFF, 8'h00, 8'h00);
        request(4'd14, 4'd15);
        check_eq("r14_ro", rs, 8'h04);
        check_eq("r15_ro", rt, 8'h02);
        block_id = 8'd9;
        update(4'd13, 2'd2, 8'hFF, 8'h00, 8'h00);
        request(4'd13, 4'd13);
        check_eq("r13_track", rs, 8'h09);

        // Disabled thread freezes everything.
        request(4'd3, 4'd3);
        enable   = 1'b0;
        block_id = 8'h44;
        request(4'd13, 4'd13);
        check_eq("dis_req_rs", rs, 8'hC3);
        update(4'd5, 2'd2, 8'h22, 8'h00, 8'h00);
        check_eq("dis_upd_rt", rt, 8'hC3);
        enable = 1'b1;
        request(4'd5, 4'd13);
        check_eq("dis_r5", rs, 8'h00);
        check_eq("dis_r13_frozen", rt, 8'h09);

        // Write-enable outside UPDATE, and the reserved mux code.
        core_state               = 3'd5;
        decoded_rd_address       = 4'd6;
        decoded_reg_input_mux    = 2'd2;
        decoded_immediate        = 8'h66;
        decoded_reg_write_enable = 1'b1;
        cycle();
        core_state = 3'd4;
        cycle();
        decoded_reg_write_enable = 1'b0;
        update(4'd6, 2'd3, 8'h66, 8'h66, 8'h66);
        request(4'd6, 4'd6);
        check_eq("we_outside_upd", rs, 8'h00);

        // Reset in the middle of an instruction.
        update(4'd1, 2'd2, 8'h33, 8'h00, 8'h00);
        request(4'd1, 4'd1);
        check_eq("r1_written", rs, 8'h33);
        core_state = 3'd4;
        reset      = 1'b1;
        cycle();
        check_eq("midrst_rs", rs, 8'h00);
        check_eq("midrst_rt", rt, 8'h00);
        reset = 1'b0;
        request(4'd1, 4'd14);
        check_eq("midrst_r1", rs, 8'h00);
        check_eq("midrst_r14", rt, 8'h04);
        request(4'd15, 4'd15);
        check_eq("midrst_r15", rs, 8'h02);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset                    = ($urandom_range(0, 199) == 0);
            enable                   = ($urandom_range(0, 9) != 0);
            block_id                 = DB'($urandom);
            core_state               = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom);
            decoded_rd_address       = 4'($urandom);
            decoded_rs_address       = 4'($urandom);
            decoded_rt_address       = 4'($urandom);
            decoded_reg_write_enable = 1'($urandom);
            decoded_reg_input_mux    = 2'($urandom);
            decoded_immediate        = DB'($urandom);
            alu_out                  = DB'($urandom);
            lsu_out                  = DB'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule : tb_thread_regfile
